peripheral_spram_pipe: RTL
==========================

Name: peripheral_spram_pipe

Overview:
Parametrised single-port synchronous RAM. It is the next generation of the team's SPRAM peripheral wrapper.
- Generalises the fixed 2-lane write enable to DW/8 byte lanes.
- Adds a selectable 1- or 2-cycle registered read latency with a read-data valid strobe.
- Adds read-first or write-first collision mode.
- Adds out-of-range address detection.
It sits between a CPU/bus memory port and on-chip RAM, and is synthesisable as inferred block RAM.

Parameters:
AW, 7, address bus width in words
DW, 16, data bus width in bits; must be a multiple of 8
MEM_SIZE, 256, memory size in bytes; must be a multiple of DW/8; DEPTH = MEM_SIZE/(DW/8) words
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
WR_MODE, 0, 0 = read-first (a write returns old word), 1 = write-first (a write returns the merged new word)

Ports:
ram_clk  input  1  RAM clock, all logic on rising edge
ram_rst  input  1  reset, synchronous, active-high
ram_addr  input  AW  word address
ram_din  input  DW  write data
ram_cen  input  1  chip enable, low active
ram_wen  input  DW/8  per-byte write enable, low active; bit i controls din[8i+7:8i]
ram_dout  output  DW  read data, registered
ram_dvalid  output  1  one-cycle pulse, ram_dout carries the result of an access
ram_err  output  1  one-cycle pulse aligned with ram_dvalid, the access address was >= DEPTH

Behaviour:
- Access occurs on a rising edge with ram_cen=0 and ram_rst=0. Every access, read or write, produces a response.
- Write: each byte lane with ram_wen[i]=0 is updated; lanes with ram_wen[i]=1 keep their contents. All-ones ram_wen is a pure read.
- Response data:
  - WR_MODE=0: pre-write word.
  - WR_MODE=1: post-merge word, new bytes in written lanes and old bytes elsewhere.
- Latency: an access at edge N gives ram_dout/ram_dvalid valid after edge N+RD_LATENCY-1+1.
  - RD_LATENCY=1: visible in the cycle after the access edge.
  - RD_LATENCY=2: one extra output register stage; valid one cycle later.
- Back-to-back accesses every cycle are fully pipelined. Responses come in order with throughput 1 per cycle.
- ram_dout holds its last value when ram_dvalid=0. It never changes without ram_dvalid.
- Out-of-range (ram_addr >= DEPTH; only possible when 2^AW > DEPTH):
  - the write is suppressed and memory is unchanged;
  - the response data is all zeros;
  - ram_err=1 with ram_dvalid=1.
- Back-to-back write then read of the same address returns the new data. There is no hazard, because the array write completes at the access edge.
- Reset (ram_rst=1 at an edge):
  - ram_dout=0, ram_dvalid=0, ram_err=0, and all pipeline valid bits are cleared;
  - in-flight reads are discarded and never produce ram_dvalid;
  - accesses presented while ram_rst=1 are ignored, including writes;
  - memory array contents are not reset. Power-up contents are undefined in hardware and X in simulation.
- Reset deasserted at edge N: an access at edge N+1 is accepted normally.
- Illegal parameters (DW%8≠0, MEM_SIZE%(DW/8)≠0, RD_LATENCY∉{1,2}, 2^AW<DEPTH) stop elaboration with a fatal message.
- No combinational path from inputs to outputs.

Test Plan:
1. Defaults, RD_LATENCY=1: write 0xBEEF to addr 5 (wen=2'b00), then read addr 5 → ram_dvalid=1 with ram_dout=0xBEEF one cycle after the read edge; ram_err=0.
2. Byte lanes: addr 9 holds 0x1234; write din=0xABCD with wen=2'b10 → read returns 0x12CD. Then write with wen=2'b01 → read returns 0xABCD. With DW=32, wen=4'b1010 writes lanes 0 and 2 only.
3. Collision mode: addr 3 holds 0x1111; write 0x2222 → response 0x1111 with WR_MODE=0, 0x2222 with WR_MODE=1.
4. RD_LATENCY=2 streaming: reads of addr 0..7 on 8 consecutive edges, with contents addr*0x0101 → 8 consecutive ram_dvalid pulses starting 2 cycles after the first read, data 0x0000..0x0707 in order.
5. Out-of-range: MEM_SIZE=200, AW=7 (DEPTH=100); write 0xFFFF to addr 100, then read addr 100 → response 0x0000 with ram_err=1; addr 99 contents unchanged.
6. Reset mid-operation: RD_LATENCY=2; read issued, and ram_rst=1 on the next edge → no ram_dvalid appears; ram_dout=0. A write asserted during reset leaves the target word unchanged. A read at the first edge after reset returns the correct data.

Source files
------------

// File: rtl/peripheral_spram_pipe.sv
// peripheral_spram_pipe: single-port synchronous RAM with DW/8 byte lanes,
// 1- or 2-cycle registered read latency with a valid strobe, read-first or
// write-first collision behaviour and out-of-range address detection.
module peripheral_spram_pipe #(
    parameter int AW         = 7,
    parameter int DW         = 16,
    parameter int MEM_SIZE   = 256,
    parameter int RD_LATENCY = 1,
    parameter int WR_MODE    = 0
) (
    input  logic            ram_clk,
    input  logic            ram_rst,
    input  logic [AW-1:0]   ram_addr,
    input  logic [DW-1:0]   ram_din,
    input  logic            ram_cen,
    input  logic [DW/8-1:0] ram_wen,
    output logic [DW-1:0]   ram_dout,
    output logic            ram_dvalid,
    output logic            ram_err
);

    localparam int NB = (DW >= 8) ? DW / 8 : 1;
    localparam int DEPTH = MEM_SIZE / NB;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    // Elaboration-time sanity checks on the parameter set
    if (DW % 8 != 0 || DW < 8) begin : g_bad_dw
        $fatal(1, "peripheral_spram_pipe: DW must be a non-zero multiple of 8");
    end
    if (MEM_SIZE % NB != 0 || DEPTH < 1) begin : g_bad_size
        $fatal(1, "peripheral_spram_pipe: MEM_SIZE must be a non-zero multiple of DW/8");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
        $fatal(1, "peripheral_spram_pipe: RD_LATENCY must be 1 or 2");
    end
    if (AW < 31 && (1 << AW) < DEPTH) begin : g_bad_aw
        $fatal(1, "peripheral_spram_pipe: 2**AW is smaller than DEPTH");
    end

    logic [DW-1:0] mem [DEPTH];

    logic          access;
    logic          in_range;
    logic [IW-1:0] idx;
    logic [DW-1:0] old_word;
    logic [DW-1:0] new_word;
    logic [DW-1:0] resp;

    logic          s1_valid;
    logic          s1_err;
    logic [DW-1:0] s1_data;

    // Decode the current request: accepted only out of reset with chip enable low
    always_comb begin
        access   = !ram_rst && !ram_cen;
        in_range = {1'b0, ram_addr} < DEPTH_W;
        idx      = ram_addr[IW-1:0];
    end

    // Build the old and merged words and pick the response by collision mode
    always_comb begin
        old_word = mem[idx];
        new_word = old_word;
        for (int i = 0; i < NB; i++) begin
            if (!ram_wen[i]) begin
                new_word[8*i +: 8] = ram_din[8*i +: 8];
            end
        end
        if (!in_range) begin
            resp = '0;
        end else if (WR_MODE == 1) begin
            resp = new_word;
        end else begin
            resp = old_word;
        end
    end

    // Byte-lane array write; out-of-range writes are dropped, array has no reset
    always_ff @(posedge ram_clk) begin
        if (access && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (!ram_wen[i]) begin
                    mem[idx][8*i +: 8] <= ram_din[8*i +: 8];
                end
            end
        end
    end

    // First response stage; data only moves when a response is produced
    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= access;
            s1_err   <= access && !in_range;
            if (access) begin
                s1_data <= resp;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic          s2_valid;
        logic          s2_err;
        logic [DW-1:0] s2_data;

        // Extra output register stage; reset discards anything in flight
        always_ff @(posedge ram_clk) begin
            if (ram_rst) begin
                s2_valid <= 1'b0;
                s2_err   <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                s2_err   <= s1_err;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign ram_dout   = s2_data;
        assign ram_dvalid = s2_valid;
        assign ram_err    = s2_err;
    end else begin : g_lat1
        assign ram_dout   = s1_data;
        assign ram_dvalid = s1_valid;
        assign ram_err    = s1_err;
    end

endmodule
